// File: rtl/dmem_initiator.sv
// dmem_initiator: initiator side of the data-memory port.
//
// Turns CPU load/store requests into the word-addressed memwrite/byteen/ack protocol of the
// data cache. Handles byte/half/word sizing with big-endian lane steering (byte offset 0 is
// bits 31:24). Loads are extracted and sign/zero extended. Stores use a four-phase handshake:
// memwrite is held until dataack rises, then released, then the block waits for dataack to
// fall.
//
// Optional feature: define DMEM_TIMEOUT_EN to abort a store that stays in the request or
// release phase for TIMEOUT_CYCLES cycles (reported as resp_err).
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   req_*             CPU request (valid/ready handshake), byte address, right-justified data
//   resp_*            one-cycle completion pulse with error flag and extended load data
//   memwrite          write strobe to the cache
//   dataadr           word-aligned address (bits 1:0 always zero)
//   writedata/byteen  lane-steered store data and byte enables
//   readdata          cache read data, combinational from dataadr
//   dataack           cache write acknowledge
module dmem_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned CNT_W          = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        memwrite,
    output logic [31:0] dataadr,
    output logic [31:0] writedata,
    output logic [3:0]  byteen,
    input  logic [31:0] readdata,
    input  logic        dataack
);

    // The timeout counter must be able to hold TIMEOUT_CYCLES.
    if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cnt_w_check
        $error("dmem_initiator: CNT_W too narrow for TIMEOUT_CYCLES");
    end

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWrReq,
        StWrRel,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        signed_q, signed_d;
    logic        memwrite_q, memwrite_d;
    logic [31:0] dataadr_q, dataadr_d;
    logic [31:0] writedata_q, writedata_d;
    logic [3:0]  byteen_q, byteen_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

`ifdef DMEM_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic        accept;
    logic        misaligned;
    logic [3:0]  req_byteen;
    logic [31:0] req_wsteer;

    // reset is included so the CPU never sees a ready while the block is held in reset.
    assign req_ready = (state_q == StIdle) && !dataack && !reset;
    assign accept    = req_valid && req_ready;

    always_comb begin
        misaligned = 1'b0;
        unique case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Big-endian lane selection: offset 0 maps to byteen[3] / bits 31:24.
    always_comb begin
        req_byteen = 4'b1111;
        req_wsteer = req_wdata;
        unique case (req_size)
            2'b00: begin
                req_byteen = 4'b1000 >> req_addr[1:0];
                req_wsteer = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_byteen = req_addr[1] ? 4'b0011 : 4'b1100;
                req_wsteer = {2{req_wdata[15:0]}};
            end
            default: begin
                req_byteen = 4'b1111;
                req_wsteer = req_wdata;
            end
        endcase
    end

    function automatic logic [31:0] load_extract(input logic [31:0] rd, input logic [1:0] size,
                                                 input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        unique case (off)
            2'd0:    b = rd[31:24];
            2'd1:    b = rd[23:16];
            2'd2:    b = rd[15:8];
            default: b = rd[7:0];
        endcase
        h = off[1] ? rd[15:0] : rd[31:16];
        unique case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        off_d        = off_q;
        signed_d     = signed_q;
        memwrite_d   = memwrite_q;
        dataadr_d    = dataadr_q;
        writedata_d  = writedata_q;
        byteen_d     = byteen_q;
        // Response fields are only meaningful for the single RESP cycle.
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
`ifdef DMEM_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    size_d   = req_size;
                    off_d    = req_addr[1:0];
                    signed_d = req_signed;
                    if (misaligned) begin
                        // No memory access: address/data/lane registers keep their value.
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_write) begin
                        state_d     = StWrReq;
                        memwrite_d  = 1'b1;
                        dataadr_d   = {req_addr[31:2], 2'b00};
                        writedata_d = req_wsteer;
                        byteen_d    = req_byteen;
`ifdef DMEM_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end else begin
                        state_d   = StRd;
                        dataadr_d = {req_addr[31:2], 2'b00};
                    end
                end
            end

            StRd: begin
                // dataack is irrelevant here; readdata is sampled at the end of this cycle.
                state_d      = StResp;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_extract(readdata, size_q, off_q, signed_q);
            end

            StWrReq: begin
                if (dataack) begin
                    state_d    = StWrRel;
                    memwrite_d = 1'b0;
`ifdef DMEM_TIMEOUT_EN
                    cnt_d      = '0;
                end else if (cnt_q == CntLast) begin
                    state_d      = StResp;
                    memwrite_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end

            StWrRel: begin
                if (!dataack) begin
                    state_d      = StResp;
                    resp_valid_d = 1'b1;
`ifdef DMEM_TIMEOUT_EN
                end else if (cnt_q == CntLast) begin
                    state_d      = StResp;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end

            StResp: begin
                state_d = StIdle;
            end

            default: begin
                state_d    = StIdle;
                memwrite_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            signed_q     <= 1'b0;
            memwrite_q   <= 1'b0;
            dataadr_q    <= 32'h0;
            writedata_q  <= 32'h0;
            byteen_q     <= 4'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
`ifdef DMEM_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            off_q        <= off_d;
            signed_q     <= signed_d;
            memwrite_q   <= memwrite_d;
            dataadr_q    <= dataadr_d;
            writedata_q  <= writedata_d;
            byteen_q     <= byteen_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
`ifdef DMEM_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign memwrite   = memwrite_q;
    assign dataadr    = dataadr_q;
    assign writedata  = writedata_q;
    assign byteen     = byteen_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_initiator.sv
// Bench for dmem_initiator: a cache model with a 3-cycle ack delay, a table of requests whose
// expected responses are queued at acceptance and checked when resp_valid fires, plus hand
// sequences for ack-blocking, back-to-back stores, reset mid-write and (optionally) timeout.
module tb_dmem_initiator;
    localparam int AckDelay = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, memwrite, dataack;
    logic [31:0] resp_rdata, dataadr, writedata, readdata;
    logic [3:0]  byteen;

    always #5 clk = ~clk;

    dmem_initiator dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_size  (req_size),
        .req_signed(req_signed),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_err  (resp_err),
        .resp_rdata(resp_rdata),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .byteen    (byteen),
        .readdata  (readdata),
        .dataack   (dataack)
    );

    // ---------------- cache model ----------------
    logic [31:0] mem [64];
    logic        ack_q;
    int          dcnt;
    logic        ack_force, ack_mute;
    int          cyc = 0;

    assign dataack  = ack_q | ack_force;
    assign readdata = mem[dataadr[7:2]];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i+:8] = be[i] ? nw[8*i+:8] : old[8*i+:8];
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q <= 1'b0;
            dcnt  <= 0;
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else if (!ack_mute && (memwrite != ack_q)) begin
            if (dcnt == AckDelay - 1) begin
                ack_q <= memwrite;
                dcnt  <= 0;
                if (memwrite) mem[dataadr[7:2]] <= merge(mem[dataadr[7:2]], writedata, byteen);
            end else begin
                dcnt <= dcnt + 1;
            end
        end else begin
            dcnt <= 0;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    typedef struct {
        int          id;
        logic [31:0] rd;
        logic        err;
        int          t;
        int          lat;
        int          mw0;
        int          mw;
    } sb_t;

    sb_t sb[$];
    int  mw_total = 0;

    initial begin
        sb_t  e;
        logic mw_prev;
        mw_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (memwrite) mw_total++;
                // A new write strobe must never start while the cache still acks the last one.
                if (memwrite && !mw_prev) check("memwrite rise vs dataack", {31'h0, dataack}, 0);
                mw_prev = memwrite;
                if (resp_valid) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected resp_valid: got 1 expected 0");
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("t%0d resp_err", e.id), {31'h0, resp_err}, {31'h0, e.err});
                        check($sformatf("t%0d resp_rdata", e.id), resp_rdata, e.rd);
                        check($sformatf("t%0d latency", e.id), cyc - e.t, e.lat);
                        check($sformatf("t%0d memwrite cycles", e.id), mw_total - e.mw0, e.mw);
                    end
                end
            end else begin
                mw_prev = 1'b0;
            end
        end
    end

    // Drives one request, waits (bounded) for acceptance, queues the expected response.
    task automatic drive_req(input int id, input logic wr, input logic [1:0] sz,
                             input logic sg, input logic [31:0] ad, input logic [31:0] wd,
                             input logic [3:0] ebe, input logic [31:0] ewd,
                             input logic eerr, input logic [31:0] erd, input int elat,
                             input int emw, input bit keep);
        int  n;
        sb_t e;
        @(negedge clk);
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = ad;
        req_wdata  = wd;
        req_valid  = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL t%0d accept: got no req_ready expected req_ready within 200 cycles",
                     id);
            req_valid = 1'b0;
            return;
        end
        check($sformatf("t%0d dataack at accept", id), {31'h0, dataack}, 0);
        e.id  = id;
        e.rd  = erd;
        e.err = eerr;
        e.t   = cyc;
        e.lat = elat;
        e.mw0 = mw_total;
        e.mw  = emw;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
        if (wr && !eerr) begin
            check($sformatf("t%0d memwrite", id), {31'h0, memwrite}, 1);
            check($sformatf("t%0d dataadr", id), dataadr, {ad[31:2], 2'b00});
            check($sformatf("t%0d byteen", id), {28'h0, byteen}, {28'h0, ebe});
            check($sformatf("t%0d writedata", id), writedata, ewd);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard drained", sb.size(), 0);
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] ad;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] ewd;
        logic        err;
        logic [31:0] rd;
        int          lat;
        int          mw;
    } vec_t;

    vec_t vecs[18];

    initial begin
        vecs[0]  = '{1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 0, 32'h0, 9, 4};
        vecs[1]  = '{0, 2'b10, 0, 32'h10, 32'h0, 4'h0, 32'h0, 0, 32'hDEADBEEF, 2, 0};
        vecs[2]  = '{1, 2'b00, 0, 32'h13, 32'h000000A5, 4'b0001, 32'hA5A5A5A5, 0, 32'h0, 9, 4};
        vecs[3]  = '{0, 2'b00, 1, 32'h13, 32'h0, 4'h0, 32'h0, 0, 32'hFFFFFFA5, 2, 0};
        vecs[4]  = '{0, 2'b00, 0, 32'h13, 32'h0, 4'h0, 32'h0, 0, 32'h000000A5, 2, 0};
        vecs[5]  = '{0, 2'b10, 0, 32'h10, 32'h0, 4'h0, 32'h0, 0, 32'hDEADBEA5, 2, 0};
        vecs[6]  = '{1, 2'b01, 0, 32'h22, 32'h00008001, 4'b0011, 32'h80018001, 0, 32'h0, 9, 4};
        vecs[7]  = '{0, 2'b01, 1, 32'h22, 32'h0, 4'h0, 32'h0, 0, 32'hFFFF8001, 2, 0};
        vecs[8]  = '{0, 2'b01, 1, 32'h21, 32'h0, 4'h0, 32'h0, 1, 32'h0, 1, 0};
        vecs[9]  = '{1, 2'b00, 0, 32'h20, 32'h1234567E, 4'b1000, 32'h7E7E7E7E, 0, 32'h0, 9, 4};
        vecs[10] = '{0, 2'b00, 1, 32'h20, 32'h0, 4'h0, 32'h0, 0, 32'h0000007E, 2, 0};
        vecs[11] = '{0, 2'b10, 0, 32'h20, 32'h0, 4'h0, 32'h0, 0, 32'h7E008001, 2, 0};
        vecs[12] = '{1, 2'b10, 0, 32'h31, 32'h12345678, 4'h0, 32'h0, 1, 32'h0, 1, 0};
        vecs[13] = '{0, 2'b11, 0, 32'h40, 32'h0, 4'h0, 32'h0, 1, 32'h0, 1, 0};
        vecs[14] = '{0, 2'b01, 0, 32'h20, 32'h0, 4'h0, 32'h0, 0, 32'h00007E00, 2, 0};
        vecs[15] = '{1, 2'b01, 0, 32'h30, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF, 0, 32'h0, 9, 4};
        vecs[16] = '{0, 2'b01, 1, 32'h30, 32'h0, 4'h0, 32'h0, 0, 32'hFFFFBEEF, 2, 0};
        vecs[17] = '{0, 2'b00, 0, 32'h11, 32'h0, 4'h0, 32'h0, 0, 32'h000000AD, 2, 0};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        ack_force  = 1'b0;
        ack_mute   = 1'b0;

        repeat (2) @(negedge clk);
        check("reset req_ready", {31'h0, req_ready}, 0);
        check("reset resp_valid", {31'h0, resp_valid}, 0);
        check("reset memwrite", {31'h0, memwrite}, 0);
        check("reset dataadr", dataadr, 0);
        check("reset byteen", {28'h0, byteen}, 0);
        check("reset writedata", writedata, 0);
        reset = 1'b0;
        #1;
        check("post-reset req_ready", {31'h0, req_ready}, 1);

        foreach (vecs[i]) begin
            drive_req(i, vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].ad, vecs[i].wd,
                      vecs[i].be, vecs[i].ewd, vecs[i].err, vecs[i].rd, vecs[i].lat,
                      vecs[i].mw, 1'b0);
        end
        drain();

        // dataack high while idle blocks acceptance.
        @(negedge clk);
        ack_force  = 1'b1;
        req_write  = 1'b0;
        req_size   = 2'b10;
        req_addr   = 32'h10;
        req_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("ack-high blocks ready %0d", i), {31'h0, req_ready}, 0);
        end
        ack_force = 1'b0;
        req_valid = 1'b0;
        #1;
        check("ready after ack falls", {31'h0, req_ready}, 1);

        // dataack during RD is ignored.
        drive_req(20, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 4'h0, 32'h0, 1'b0, 32'hFFFFFFA5, 2, 0,
                  1'b0);
        ack_force = 1'b1;
        repeat (2) @(negedge clk);
        ack_force = 1'b0;
        drain();

        // Back-to-back stores with req_valid held high.
        drive_req(21, 1'b1, 2'b10, 1'b0, 32'h50, 32'h11111111, 4'b1111, 32'h11111111, 1'b0,
                  32'h0, 9, 4, 1'b1);
        drive_req(22, 1'b1, 2'b10, 1'b0, 32'h54, 32'h22222222, 4'b1111, 32'h22222222, 1'b0,
                  32'h0, 9, 4, 1'b0);
        drive_req(23, 1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 4'h0, 32'h0, 1'b0, 32'h11111111, 2, 0,
                  1'b0);
        drive_req(24, 1'b0, 2'b10, 1'b0, 32'h54, 32'h0, 4'h0, 32'h0, 1'b0, 32'h22222222, 2, 0,
                  1'b0);
        drain();

        // Reset asserted during the write request phase.
        drive_req(25, 1'b1, 2'b10, 1'b0, 32'h40, 32'h33445566, 4'b1111, 32'h33445566, 1'b0,
                  32'h0, 9, 4, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async reset memwrite", {31'h0, memwrite}, 0);
        check("async reset resp_valid", {31'h0, resp_valid}, 0);
        check("async reset req_ready", {31'h0, req_ready}, 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ready after reset release", {31'h0, req_ready}, 1);
        drive_req(26, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 1'b0,
                  32'h0, 9, 4, 1'b0);
        drive_req(27, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b0, 32'hCAFEF00D, 2, 0,
                  1'b0);
        drain();

`ifdef DMEM_TIMEOUT_EN
        // Cache never acks: the store aborts after 15 request-phase cycles.
        ack_mute = 1'b1;
        drive_req(28, 1'b1, 2'b10, 1'b0, 32'h44, 32'h0BADF00D, 4'b1111, 32'h0BADF00D, 1'b1,
                  32'h0, 16, 15, 1'b0);
        drain();
        ack_mute = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
